// File: rtl/obstacle_pkg.sv
// Shared constants, field widths and slot record for the multi-slot obstacle pool.
package obstacle_pkg;

  localparam int unsigned N_SLOTS_DEF     = 3;
  localparam int unsigned D_WIDTH_DEF     = 640;
  localparam int unsigned FLOOR_Y_DEF     = 400;
  localparam int unsigned HALF_W_DEF      = 12;
  localparam int unsigned CACTUS_HMIN_DEF = 16;
  localparam int unsigned BIRD_HALF_H_DEF = 8;
  localparam int unsigned BIRD_Y_MAX_DEF  = 340;
  localparam int unsigned WAIT_MIN_DEF    = 60;

  localparam int unsigned LFSR_W        = 16;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;  // taps 16,14,13,11, right-shift Galois
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam int unsigned RND_W         = 12;        // only rnd[11:0] feeds spawn decisions

  localparam int unsigned X_W    = 13;
  localparam int unsigned Y_W    = 12;
  localparam int unsigned H_W    = 8;
  localparam int unsigned EDGE_W = 12;

  typedef enum logic {
    TYPE_CACTUS = 1'b0,
    TYPE_BIRD   = 1'b1
  } obs_type_e;

  typedef struct packed {
    logic                    active;
    obs_type_e               kind;
    logic signed [X_W-1:0]   x;
    logic        [Y_W-1:0]   y;
    logic        [H_W-1:0]   hh;
  } slot_t;

endpackage

// File: rtl/pool_lfsr.sv
// Free-running 16-bit Galois LFSR shared by every obstacle slot.
module pool_lfsr
  import obstacle_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [RND_W-1:0] o_rnd
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign o_rnd = lfsr_q[RND_W-1:0];

endmodule

// File: rtl/obstacle_pool.sv
// N-slot obstacle manager: one spawn timer and one LFSR feed all slots,
// each slot scrolls left at the runtime speed and reports its bounding box.
module obstacle_pool
  import obstacle_pkg::*;
#(
  parameter int unsigned N_SLOTS     = N_SLOTS_DEF,
  parameter int unsigned D_WIDTH     = D_WIDTH_DEF,
  parameter int unsigned FLOOR_Y     = FLOOR_Y_DEF,
  parameter int unsigned HALF_W      = HALF_W_DEF,
  parameter int unsigned CACTUS_HMIN = CACTUS_HMIN_DEF,
  parameter int unsigned BIRD_HALF_H = BIRD_HALF_H_DEF,
  parameter int unsigned BIRD_Y_MAX  = BIRD_Y_MAX_DEF,
  parameter int unsigned WAIT_MIN    = WAIT_MIN_DEF,
  parameter bit          BIRD_EN     = 1'b1,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ani_stb,
  input  logic                      i_animate,
  input  logic                      i_grace,
  input  logic [3:0]                i_speed,
  output logic [N_SLOTS-1:0]        o_active,
  output logic [N_SLOTS-1:0]        o_type,
  output logic [EDGE_W*N_SLOTS-1:0] o_x1,
  output logic [EDGE_W*N_SLOTS-1:0] o_x2,
  output logic [EDGE_W*N_SLOTS-1:0] o_y1,
  output logic [EDGE_W*N_SLOTS-1:0] o_y2,
  output logic                      o_spawn,
  output logic                      o_passed
);

  localparam int unsigned TIMER_W = $clog2(WAIT_MIN + 64);
  localparam int          X_GONE_I = -int'(HALF_W);
  localparam logic signed [X_W-1:0] X_GONE  = X_W'(X_GONE_I);
  localparam logic signed [X_W-1:0] X_SPAWN = X_W'(D_WIDTH + HALF_W);
  localparam logic        [X_W-1:0] HALF_W_X = X_W'(HALF_W);

  logic [RND_W-1:0]   rnd;
  logic               tick;
  logic [N_SLOTS-1:0] active_v, despawn_v, fill_v;
  logic               free_any, spawn_now;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               spawn_q, passed_q;
  obs_type_e          new_kind;
  logic [H_W-1:0]     new_hh;
  logic [Y_W-1:0]     new_y;

  pool_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_rnd (rnd)
  );

  assign tick = i_ani_stb & i_animate;

  // Freeness uses pre-tick state, so a slot despawning now is not refilled until the next tick.
  always_comb begin
    fill_v   = '0;
    free_any = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (!active_v[k] && !free_any) begin
        fill_v[k] = 1'b1;
        free_any  = 1'b1;
      end
    end
  end

  assign spawn_now = tick & ~i_grace & (timer_q == '0) & free_any;

  always_comb begin
    new_kind = (BIRD_EN && rnd[7:6] == 2'b11) ? TYPE_BIRD : TYPE_CACTUS;
    if (new_kind == TYPE_BIRD) begin
      new_hh = H_W'(BIRD_HALF_H);
      new_y  = Y_W'(BIRD_Y_MAX) - {{(Y_W-6){1'b0}}, rnd[11:8], 2'b00};
    end else begin
      new_hh = H_W'(CACTUS_HMIN) + {{(H_W-4){1'b0}}, rnd[11:8]};
      new_y  = Y_W'(FLOOR_Y) - {{(Y_W-H_W){1'b0}}, new_hh};
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    timer_d = timer_q;
    if (tick && !i_grace) begin
      if (timer_q != '0) timer_d = timer_q - TIMER_W'(1);
      else if (free_any) timer_d = TIMER_W'(WAIT_MIN) + TIMER_W'(rnd[5:0]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer_q  <= TIMER_W'(WAIT_MIN);
      spawn_q  <= 1'b0;
      passed_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      spawn_q  <= spawn_now;
      passed_q <= tick & (|despawn_v);
    end
  end

  assign o_spawn  = spawn_q;
  assign o_passed = passed_q;

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    slot_t slot_q, slot_d;

    assign active_v[k]  = slot_q.active;
    assign despawn_v[k] = slot_q.active && ($signed(slot_q.x) < X_GONE);

    always_comb begin
      slot_d = slot_q;
      if (tick) begin
        if (despawn_v[k])        slot_d = '0;
        else if (slot_q.active)  slot_d.x = slot_q.x - {{(X_W-4){1'b0}}, i_speed};
        else if (spawn_now && fill_v[k])
          slot_d = '{active: 1'b1, kind: new_kind, x: X_SPAWN, y: new_y, hh: new_hh};
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) slot_q <= '0;
      else       slot_q <= slot_d;
    end

    // Edges wrap in two's complement while the obstacle straddles the left border.
    assign o_active[k] = slot_q.active;
    assign o_type[k]   = slot_q.active & (slot_q.kind == TYPE_BIRD);
    assign o_x1[EDGE_W*k +: EDGE_W] = slot_q.active ? EDGE_W'(slot_q.x - HALF_W_X) : '0;
    assign o_x2[EDGE_W*k +: EDGE_W] = slot_q.active ? EDGE_W'(slot_q.x + HALF_W_X) : '0;
    assign o_y1[EDGE_W*k +: EDGE_W] =
      slot_q.active ? EDGE_W'(slot_q.y - {{(Y_W-H_W){1'b0}}, slot_q.hh}) : '0;
    assign o_y2[EDGE_W*k +: EDGE_W] =
      slot_q.active ? EDGE_W'(slot_q.y + {{(Y_W-H_W){1'b0}}, slot_q.hh}) : '0;
  end

endmodule

// File: tb/tb_obstacle_pool.sv
// Directed bench for obstacle_pool: a behavioural model predicts every output
// cycle into a queue; the DUT instances (birds on / birds off) are compared against it.
module tb_obstacle_pool;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ani_stb, i_animate, i_grace;
  logic [3:0]  i_speed;

  logic [2:0]  a_active, a_type, b_active, b_type;
  logic [35:0] a_x1, a_x2, a_y1, a_y2, b_x1, b_x2, b_y1, b_y2;
  logic        a_spawn, a_passed, b_spawn, b_passed;

  obstacle_pool dut_a (
    .i_clk (i_clk), .i_rst (i_rst), .i_ani_stb (i_ani_stb), .i_animate (i_animate),
    .i_grace (i_grace), .i_speed (i_speed), .o_active (a_active), .o_type (a_type),
    .o_x1 (a_x1), .o_x2 (a_x2), .o_y1 (a_y1), .o_y2 (a_y2),
    .o_spawn (a_spawn), .o_passed (a_passed)
  );

  obstacle_pool #(.BIRD_EN(1'b0)) dut_b (
    .i_clk (i_clk), .i_rst (i_rst), .i_ani_stb (i_ani_stb), .i_animate (i_animate),
    .i_grace (i_grace), .i_speed (i_speed), .o_active (b_active), .o_type (b_type),
    .o_x1 (b_x1), .o_x2 (b_x2), .o_y1 (b_y1), .o_y2 (b_y2),
    .o_spawn (b_spawn), .o_passed (b_passed)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit active;
    bit bird;
    int x;
    int y;
    int hh;
  } m_slot_t;

  typedef struct {
    logic [2:0]  act;
    logic [2:0]  typ;
    logic [35:0] x1, x2, y1, y2;
    logic        sp, ps;
  } exp_t;

  m_slot_t     ms[2][3];
  int          m_timer;
  logic [15:0] m_lfsr;
  exp_t        q_a[$], q_b[$];
  int          n_vec = 0, n_bad = 0;
  string       phase = "reset";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic m_slot_t spawn_rec(input bit bird_en, input logic [15:0] r);
    m_slot_t s;
    s.active = 1'b1;
    s.bird   = bird_en && (r[7:6] == 2'b11);
    s.x      = 640 + 12;
    if (s.bird) begin
      s.hh = 8;
      s.y  = 340 - 4 * int'(r[11:8]);
    end else begin
      s.hh = 16 + int'(r[11:8]);
      s.y  = 400 - s.hh;
    end
    return s;
  endfunction

  function automatic exp_t model_out(input int i, input bit sp, input bit ps);
    exp_t e;
    e.act = '0; e.typ = '0; e.x1 = '0; e.x2 = '0; e.y1 = '0; e.y2 = '0;
    e.sp = sp; e.ps = ps;
    for (int k = 0; k < 3; k++) begin
      if (ms[i][k].active) begin
        e.act[k]          = 1'b1;
        e.typ[k]          = ms[i][k].bird;
        e.x1[12*k +: 12]  = 12'(ms[i][k].x - 12);
        e.x2[12*k +: 12]  = 12'(ms[i][k].x + 12);
        e.y1[12*k +: 12]  = 12'(ms[i][k].y - ms[i][k].hh);
        e.y2[12*k +: 12]  = 12'(ms[i][k].y + ms[i][k].hh);
      end
    end
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit tk, input bit grace, input int speed);
    bit          sp, ps;
    int          free;
    logic [15:0] rnd;
    sp = 1'b0;
    ps = 1'b0;
    if (rst) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 3; k++) ms[i][k] = '{default: 0};
      m_timer = 60;
      m_lfsr  = 16'hACE1;
    end else begin
      rnd = m_lfsr;
      if (tk) begin
        free = -1;
        for (int k = 0; k < 3; k++)
          if (!ms[0][k].active && free < 0) free = k;
        for (int i = 0; i < 2; i++)
          for (int k = 0; k < 3; k++)
            if (ms[i][k].active) begin
              if (ms[i][k].x + 12 < 0) begin
                ms[i][k] = '{default: 0};
                ps = 1'b1;
              end else begin
                ms[i][k].x = ms[i][k].x - speed;
              end
            end
        if (!grace) begin
          if (m_timer > 0) m_timer--;
          else if (free >= 0) begin
            ms[0][free] = spawn_rec(1'b1, rnd);
            ms[1][free] = spawn_rec(1'b0, rnd);
            m_timer     = 60 + int'(rnd[5:0]);
            sp          = 1'b1;
          end
        end
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    q_a.push_back(model_out(0, sp, ps));
    q_b.push_back(model_out(1, sp, ps));
  endtask

  task automatic compare(input string inst, input exp_t e, input exp_t o);
    check({phase, "/", inst, ".active"}, 64'(o.act), 64'(e.act));
    check({phase, "/", inst, ".type"},   64'(o.typ), 64'(e.typ));
    check({phase, "/", inst, ".x1"},     64'(o.x1),  64'(e.x1));
    check({phase, "/", inst, ".x2"},     64'(o.x2),  64'(e.x2));
    check({phase, "/", inst, ".y1"},     64'(o.y1),  64'(e.y1));
    check({phase, "/", inst, ".y2"},     64'(o.y2),  64'(e.y2));
    check({phase, "/", inst, ".spawn"},  64'(o.sp),  64'(e.sp));
    check({phase, "/", inst, ".passed"}, 64'(o.ps),  64'(e.ps));
  endtask

  // One clock: drive, predict, then compare just after the edge.
  task automatic cycle(input bit rst, input bit ani, input bit anim, input bit grace,
                       input int speed);
    exp_t ea, eb, oa, ob;
    i_rst = rst; i_ani_stb = ani; i_animate = anim; i_grace = grace; i_speed = 4'(speed);
    model_step(rst, ani && anim, grace, speed);
    @(posedge i_clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    oa = '{a_active, a_type, a_x1, a_x2, a_y1, a_y2, a_spawn, a_passed};
    ob = '{b_active, b_type, b_x1, b_x2, b_y1, b_y2, b_spawn, b_passed};
    compare("A", ea, oa);
    compare("B", eb, ob);
  endtask

  task automatic tick(input bit grace, input int speed, output bit sp, output bit ps);
    cycle(1'b0, 1'b1, 1'b1, grace, speed);
    sp = a_spawn;
    ps = a_passed;
    cycle(1'b0, 1'b0, 1'b1, grace, speed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sp, ps, done;
    int quiet, pred, spd;

    i_rst = 1'b1; i_ani_stb = 1'b0; i_animate = 1'b0; i_grace = 1'b0; i_speed = 4'd0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("reset.active", 64'(a_active), 64'd0);
    check("reset.x1",     64'(a_x1),     64'd0);
    check("reset.y2",     64'(a_y2),     64'd0);
    check("reset.pulses", 64'({a_spawn, a_passed}), 64'd0);

    phase = "grace";
    repeat (10) tick(1'b1, 1, sp, ps);
    check("grace.active", 64'(a_active), 64'd0);

    phase = "countdown";
    quiet = 0;
    done  = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      tick(1'b0, 1, sp, ps);
      if (sp) done = 1'b1;
      else    quiet++;
    end
    check("first.quiet_ticks", 64'(quiet), 64'd60);
    check("first.active",      64'(a_active), 64'b001);
    check("first.x1",          64'(a_x1[11:0]), 64'd640);
    check("first.x2",          64'(a_x2[11:0]), 64'd664);
    check("first.cactus_y2",   64'(b_y2[11:0]), 64'd400);

    phase = "motion";
    tick(1'b0, 3, sp, ps);
    check("speed3.x2", 64'(a_x2[11:0]), 64'd661);
    tick(1'b0, 0, sp, ps);
    check("speed0.x2", 64'(a_x2[11:0]), 64'd661);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 7);
    check("noanim.x2",    64'(a_x2[11:0]), 64'd661);
    check("noanim.spawn", 64'(a_spawn),    64'd0);

    phase = "despawn";
    for (int t = 0; t < 100 && ms[0][0].x > -12; t++) begin
      spd = (ms[0][0].x + 12 > 15) ? 15 : ms[0][0].x + 12;
      tick(1'b0, spd, sp, ps);
    end
    check("edge.m12_active", 64'(a_active[0]),  64'd1);
    check("edge.m12_x1",     64'(a_x1[11:0]),   64'd4072);
    tick(1'b0, 1, sp, ps);
    check("edge.m13_active", 64'(a_active[0]),  64'd1);
    check("edge.m13_x2",     64'(a_x2[11:0]),   64'd4095);
    tick(1'b0, 1, sp, ps);
    check("gone.passed", 64'(ps),             64'd1);
    check("gone.active", 64'(a_active[0]),    64'd0);
    check("gone.x1",     64'(a_x1[11:0]),     64'd0);
    check("gone.y2",     64'(a_y2[11:0]),     64'd0);
    check("gone.pulse",  64'(a_passed),       64'd0);

    phase = "fill";
    for (int t = 0; t < 800; t++) begin
      if (ms[0][0].active && ms[0][1].active && ms[0][2].active && m_timer == 0) break;
      tick(1'b0, 0, sp, ps);
    end
    check("fill.active", 64'(a_active), 64'b111);
    repeat (3) begin
      tick(1'b0, 0, sp, ps);
      check("fill.no_spawn", 64'(sp), 64'd0);
    end

    phase = "refill";
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      pred = -1;
      for (int k = 0; k < 3; k++)
        if (ms[0][k].active && ms[0][k].x < -12 && pred < 0) pred = k;
      if (pred >= 0) begin
        tick(1'b0, 15, sp, ps);
        check("refill.despawn_passed", 64'(ps),             64'd1);
        check("refill.despawn_spawn",  64'(sp),             64'd0);
        check("refill.slot_freed",     64'(a_active[pred]), 64'd0);
        tick(1'b0, 15, sp, ps);
        check("refill.next_spawn",     64'(sp),             64'd1);
        check("refill.slot_reused",    64'(a_active[pred]), 64'd1);
        done = 1'b1;
      end else begin
        tick(1'b0, 15, sp, ps);
      end
    end
    check("refill.found", 64'(done), 64'd1);

    phase = "midreset";
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 15);
    check("midreset.active_a", 64'(a_active), 64'd0);
    check("midreset.active_b", 64'(b_active), 64'd0);
    check("midreset.pulses",   64'({a_spawn, a_passed}), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);

    phase = "bird";
    repeat (60) tick(1'b0, 1, sp, ps);
    done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (m_lfsr[7:6] == 2'b11 && m_lfsr[11:8] == 4'd5) begin
        done = 1'b1;
        break;
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1);
    end
    check("bird.lfsr_search", 64'(done), 64'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1);
    check("bird.spawn",     64'(a_spawn),     64'd1);
    check("bird.type",      64'(a_type[0]),   64'd1);
    check("bird.y1",        64'(a_y1[11:0]),  64'd312);
    check("bird.y2",        64'(a_y2[11:0]),  64'd328);
    check("nobird.type",    64'(b_type[0]),   64'd0);
    check("nobird.y1",      64'(b_y1[11:0]),  64'd358);
    check("nobird.y2",      64'(b_y2[11:0]),  64'd400);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
